// File: rtl/adder_checker_if.sv
// Operand/sum bus between the self-test sequencer (master) and the adder under test (slave).
interface adder_checker_if #(
  parameter int unsigned WIDTH = 5
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH:0]   q;

  modport master (output a, output b, input q);
  modport slave  (input a, input b, output q);
endinterface

// File: rtl/adder_checker.sv
// Exhaustive self-test sequencer for a WIDTH-bit combinational adder.
// Optional feature: define ADDER_CHECK_STOP_ON_FAIL_EN to halt the sweep on the first mismatch.
module adder_checker #(
  parameter int unsigned WIDTH         = 5,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  adder_checker_if.master      bus,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [2*WIDTH:0]     err_count,
  output logic [WIDTH-1:0]     fail_a,
  output logic [WIDTH-1:0]     fail_b,
  output logic [WIDTH:0]       fail_q
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CHECK,
    DONE
  } state_e;

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  state_e               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   vec_q, vec_d;   // {a,b}, b is the fast-moving field
  logic [2*WIDTH:0]     err_q, err_d;
  logic [WIDTH-1:0]     fail_a_q, fail_a_d;
  logic [WIDTH-1:0]     fail_b_q, fail_b_d;
  logic [WIDTH:0]       fail_q_q, fail_q_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 pass_q, pass_d;

  logic [WIDTH-1:0]     cur_a, cur_b;
  logic [WIDTH:0]       ref_sum;
  logic                 mismatch;
  logic                 last_vec;
  logic                 stop_now;
  logic                 finish;

  assign cur_a    = vec_q[2*WIDTH-1:WIDTH];
  assign cur_b    = vec_q[WIDTH-1:0];
  assign ref_sum  = {1'b0, cur_a} + {1'b0, cur_b};
  assign mismatch = (bus.q != ref_sum);
  assign last_vec = &vec_q;

`ifdef ADDER_CHECK_STOP_ON_FAIL_EN
  assign stop_now = mismatch;
`else
  assign stop_now = 1'b0;
`endif

  assign finish = last_vec || stop_now;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      vec_q    <= '0;
      err_q    <= '0;
      fail_a_q <= '0;
      fail_b_q <= '0;
      fail_q_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      vec_q    <= vec_d;
      err_q    <= err_d;
      fail_a_q <= fail_a_d;
      fail_b_q <= fail_b_d;
      fail_q_q <= fail_q_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: if (start) state_d = SETTLE;
      SETTLE:     if (cnt_q == '0) state_d = CHECK;
      CHECK:      state_d = finish ? DONE : SETTLE;
      default:    state_d = IDLE;
    endcase
  end

  // Datapath next-state: every visible output is a register, updated alongside the FSM.
  always_comb begin
    cnt_d    = cnt_q;
    vec_d    = vec_q;
    err_d    = err_q;
    fail_a_d = fail_a_q;
    fail_b_d = fail_b_q;
    fail_q_d = fail_q_q;
    busy_d   = busy_q;
    done_d   = done_q;
    pass_d   = pass_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          vec_d    = '0;
          err_d    = '0;
          fail_a_d = '0;
          fail_b_d = '0;
          fail_q_d = '0;
          busy_d   = 1'b1;
          done_d   = 1'b0;
          pass_d   = 1'b0;
          cnt_d    = CNT_LOAD;
        end
      end
      SETTLE: begin
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
      end
      CHECK: begin
        if (mismatch) begin
          err_d = err_q + 1'b1;
          if (err_q == '0) begin
            fail_a_d = cur_a;
            fail_b_d = cur_b;
            fail_q_d = bus.q;
          end
        end
        if (finish) begin
          busy_d = 1'b0;
          done_d = 1'b1;
          pass_d = !mismatch && (err_q == '0);
        end else begin
          vec_d = vec_q + 1'b1;
          cnt_d = CNT_LOAD;
        end
      end
      default: ;
    endcase
  end

  assign bus.a     = cur_a;
  assign bus.b     = cur_b;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_a    = fail_a_q;
  assign fail_b    = fail_b_q;
  assign fail_q    = fail_q_q;

endmodule

// File: tb/tb_adder_checker.sv
// Scoreboard bench for adder_checker: a behavioural adder (optionally with q[MSB] stuck at 0) closes the loop.
module tb_adder_checker;

  localparam int unsigned W = 5;
  localparam int unsigned S = 2;
  localparam int unsigned NVEC = 1 << (2 * W);

  typedef struct {
    int unsigned     cycles;
    int unsigned     err;
    logic [W-1:0]    fa;
    logic [W-1:0]    fb;
    logic [W:0]      fq;
    logic            pass;
    logic [W-1:0]    a;
    logic [W-1:0]    b;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic           fault = 1'b0;
  logic           busy, done, pass;
  logic [2*W:0]   err_count;
  logic [W-1:0]   fail_a, fail_b;
  logic [W:0]     fail_q;
  logic [W:0]     sum;

  int unsigned total = 0;
  int unsigned bad = 0;
  exp_t sb[$];

  adder_checker_if #(.WIDTH(W)) bus ();

  adder_checker #(.WIDTH(W), .SETTLE_CYCLES(S)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
    .fail_a    (fail_a),
    .fail_b    (fail_b),
    .fail_q    (fail_q)
  );

  always #5 clk = ~clk;

  assign sum   = {1'b0, bus.a} + {1'b0, bus.b};
  assign bus.q = fault ? {1'b0, sum[W-1:0]} : sum;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic flt);
    exp_t e;
    int unsigned last_idx;
    bit stop;
    e = '{cycles: 0, err: 0, fa: '0, fb: '0, fq: '0, pass: 1'b0, a: '0, b: '0};
    last_idx = NVEC - 1;
    stop = 1'b0;
    for (int unsigned i = 0; i < NVEC && !stop; i++) begin
      logic [W-1:0] va, vb;
      logic [W:0]   s, obs;
      va  = W'(i >> W);
      vb  = W'(i);
      s   = {1'b0, va} + {1'b0, vb};
      obs = flt ? {1'b0, s[W-1:0]} : s;
      if (obs != s) begin
        if (e.err == 0) begin
          e.fa = va;
          e.fb = vb;
          e.fq = obs;
        end
        e.err++;
`ifdef ADDER_CHECK_STOP_ON_FAIL_EN
        last_idx = i;
        stop = 1'b1;
`endif
      end
    end
    e.cycles = (last_idx + 1) * (S + 1);
    e.pass   = (e.err == 0);
    e.a      = W'(last_idx >> W);
    e.b      = W'(last_idx);
    return e;
  endfunction

  task automatic chk_cleared(input string pfx);
    chk({pfx, "_busy"},  busy,      0);
    chk({pfx, "_done"},  done,      0);
    chk({pfx, "_pass"},  pass,      0);
    chk({pfx, "_err"},   err_count, 0);
    chk({pfx, "_a"},     bus.a,     0);
    chk({pfx, "_b"},     bus.b,     0);
    chk({pfx, "_fa"},    fail_a,    0);
    chk({pfx, "_fb"},    fail_b,    0);
    chk({pfx, "_fq"},    fail_q,    0);
  endtask

  task automatic run_sweep(input int unsigned pulse_every);
    exp_t e;
    int unsigned cyc;
    bit seen;
    sb.push_back(model(fault));
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("go_busy", busy,      1);
    chk("go_done", done,      0);
    chk("go_pass", pass,      0);
    chk("go_err",  err_count, 0);
    chk("go_a",    bus.a,     0);
    chk("go_b",    bus.b,     0);
    chk("go_fa",   fail_a,    0);
    chk("go_fb",   fail_b,    0);
    chk("go_fq",   fail_q,    0);
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 5000) begin
      @(posedge clk); #1;
      cyc++;
      start = 1'b0;
      if (done) seen = 1'b1;
      else if (pulse_every != 0 && (cyc % pulse_every) == 0) start = 1'b1;
    end
    start = 1'b0;
    e = sb.pop_front();
    chk("done_seen", seen,      1);
    chk("cycles",    cyc,       e.cycles);
    chk("err",       err_count, e.err);
    chk("pass",      pass,      e.pass);
    chk("fail_a",    fail_a,    e.fa);
    chk("fail_b",    fail_b,    e.fb);
    chk("fail_q",    fail_q,    e.fq);
    chk("end_a",     bus.a,     e.a);
    chk("end_b",     bus.b,     e.b);
    chk("end_busy",  busy,      0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_cleared("rst");
    rst = 1'b0;
    @(posedge clk); #1;

    // clean adder
    run_sweep(0);

    // q[MSB] stuck at 0
    fault = 1'b1;
    run_sweep(0);
    fault = 1'b0;

    // reset 100 cycles into a sweep discards the pending result
    sb.push_back(model(fault));
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    chk("mid_busy", busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_cleared("midrst");
    void'(sb.pop_front());
    run_sweep(0);

    // start pulses while busy are ignored
    run_sweep(50);

    // restart directly from DONE
    run_sweep(0);

    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adder_checker.md
# adder_checker

Board-level self-test sequencer that drives both operands of the 5-bit combinational adder and checks its 6-bit sum. Sits on the opposite side of the adder from the switch inputs: it replaces SW as operand source and consumes q as its input. It sweeps all 2^(2·WIDTH) operand pairs, compares each sum against an internal reference, and reports the pass/fail verdict, the error count and the first failing vector for display on LEDR.

## Interface
- WIDTH, 5: operand width in bits; the sum is WIDTH+1 bits.
- SETTLE_CYCLES, 2: cycles operands are held before the sum is sampled; legal range 1..15.

- clk  in  1  single system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle start pulse, already debounced and synchronised by the caller.
- q  in  WIDTH+1  sum returned by the adder under test.
- a  out  WIDTH  operand A driven to the adder, registered.
- b  out  WIDTH  operand B driven to the adder, registered.
- busy  out  1  sweep in progress.
- done  out  1  sweep finished; held until the next accepted start or reset.
- pass  out  1  valid while done=1; 1 when err_count is 0.
- err_count  out  2·WIDTH+1  number of mismatching vectors; wide enough for all vectors, so it never saturates.
- fail_a, fail_b  out  WIDTH each  operands of the first mismatch.
- fail_q  out  WIDTH+1  observed q at the first mismatch.

## Operation
- Reset value of every output is 0. The FSM resets to IDLE.
- FSM states: IDLE, SETTLE, CHECK, DONE.
- IDLE or DONE with start=1:
  - a=b=0, err_count=0, fail_* = 0.
  - busy=1, done=0, pass=0.
  - Settle counter loaded with SETTLE_CYCLES-1; go to SETTLE.
- SETTLE: decrement the counter. At 0, go to CHECK.
- CHECK: compare q against the reference a+b, computed at WIDTH+1 bits with no truncation.
  - On mismatch: err_count increments. If this is the first mismatch, capture fail_a, fail_b and fail_q.
  - Vector order is the concatenation {a,b} as a counter, with b as the LSB field: b increments first, and a increments when b wraps 31→0.
  - If {a,b} is all-ones: go to DONE, busy=0, done=1, pass=(err_count after this check==0).
  - Otherwise: advance {a,b}, reload the counter, go to SETTLE.
- start while busy=1 is ignored.
- rst mid-sweep returns to IDLE with all outputs cleared on the next edge. Partial results are discarded.
- a and b change only on the CHECK→SETTLE edge and on start acceptance, so q is stable for SETTLE_CYCLES full cycles before sampling.

## Timing
- Each vector takes SETTLE_CYCLES+1 cycles.
- The start edge is cycle 0. done rises at the edge ending cycle 2^(2·WIDTH)·(SETTLE_CYCLES+1).
  - Default parameters: 1024·3 = 3072 cycles.
- q is sampled in CHECK at the edge ending the cycle. The adder is combinational, so this gives at least SETTLE_CYCLES+0 cycles of setup margin after a/b update.
- err_count and the fail_* capture update on the same edge as the CHECK decision.
- busy falls and done rises on the same edge.

## Configuration
- ADDER_CHECK_STOP_ON_FAIL_EN defined:
  - The first mismatch in CHECK goes directly to DONE: busy=0, done=1, pass=0, err_count=1.
  - a and b hold the failing vector, so the LEDs show the failing pair.
- Undefined: the sweep always runs to completion and err_count is the total mismatch count.

## Test plan
- Ideal adder model (q=a+b), start pulse:
  - done rises 3072 cycles after start.
  - pass=1, err_count=0, fail_a=fail_b=fail_q=0.
  - a=b=31 at done.
- q[5] stuck at 0, macro undefined:
  - err_count=496.
  - fail_a=1, fail_b=31, fail_q=0.
  - pass=0.
- Same fault, ADDER_CHECK_STOP_ON_FAIL_EN defined:
  - done=1, err_count=1, a=1, b=31, pass=0.
- rst asserted 100 cycles into a sweep:
  - All outputs are 0 on the next cycle.
  - A subsequent start yields the clean 3072-cycle result.
- start pulsed every 50 cycles during a sweep:
  - No effect; done still at cycle 3072.
- start pulsed again while done=1:
  - Results clear and busy=1 on the next edge.
  - A new sweep completes 3072 cycles later.
